start_stop_ctrl: RTL and testbench

- Front-end control stage that drives the run/stop enables consumed by the rng, sum_3 and counter stages.
- Inputs: raw active-low pushbutton. Work chain: synchronise to clk, debounce, detect one clean press, step a three-state run/stop FSM.
- Replaces direct edge-clocking of logic off a button. All state is in the clk domain.

---
 rtl/start_stop_ctrl_pkg.sv | 19 +
 rtl/start_stop_ctrl_if.sv | 27 ++
 rtl/start_stop_ctrl_key_debounce.sv | 43 ++++
 rtl/start_stop_ctrl.sv | 99 +++++++++
 tb/tb_start_stop_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/start_stop_ctrl_pkg.sv
// Shared state encoding and default timing constants for the start/stop control path.
package start_stop_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STOP = 2'b10
  } state_t;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned DEFAULT_CNT_W           = 19;
  localparam int unsigned DEFAULT_HOLD_CYCLES     = 100000000;

  // Width of a counter that must reach n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/start_stop_ctrl_if.sv
// Pushbutton input and run/stop enables exchanged between the control stage and its neighbours.
interface start_stop_ctrl_if;
  logic key_n;
  logic run;
  logic stop;
  logic press_pulse;
  logic key_db;
  logic clr_pulse;

  modport master (
    output key_n,
    input  run,
    input  stop,
    input  press_pulse,
    input  key_db,
    input  clr_pulse
  );

  modport slave (
    input  key_n,
    output run,
    output stop,
    output press_pulse,
    output key_db,
    output clr_pulse
  );
endinterface

// File: rtl/start_stop_ctrl_key_debounce.sv
// Two-flop synchroniser plus stable-level debounce of an active-low pushbutton.
module key_debounce
  import start_stop_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_db
);

  logic [1:0]       sync;
  logic             s_key;
  logic [CNT_W-1:0] cnt;

  // Synchroniser resets to the released level so a reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '1;
    end else begin
      sync <= {sync[0], key_n};
    end
  end

  assign s_key = ~sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      key_db <= 1'b0;
    end else if (s_key == key_db) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      key_db <= s_key;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/start_stop_ctrl.sv
// Debounced pushbutton -> single press strobe -> IDLE/RUN/STOPPED enables.
// Optional hold-to-clear behaviour is built when HOLD_CLEAR_EN is defined.
module start_stop_ctrl
  import start_stop_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEFAULT_CNT_W,
  parameter int unsigned HOLD_CYCLES     = DEFAULT_HOLD_CYCLES
) (
  input  logic clk,
  input  logic rst,
  start_stop_ctrl_if.slave bus
);

  logic   key_db;
  logic   key_db_q;
  logic   press_pulse;
  logic   clr_pulse;
  state_t state;
  state_t state_nxt;

  if (HOLD_CYCLES < 2) begin : g_bad_hold
    $error("HOLD_CYCLES must be at least 2");
  end

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_key_debounce (
    .clk    (clk),
    .rst    (rst),
    .key_n  (bus.key_n),
    .key_db (key_db)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_db_q    <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      key_db_q    <= key_db;
      press_pulse <= key_db & ~key_db_q;
    end
  end

`ifdef HOLD_CLEAR_EN
  localparam int unsigned HOLD_W = cnt_width(HOLD_CYCLES);

  logic [HOLD_W-1:0] hold_cnt;

  // Counter saturates at its terminal value, so only one strobe per hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt  <= '0;
      clr_pulse <= 1'b0;
    end else if (!key_db) begin
      hold_cnt  <= '0;
      clr_pulse <= 1'b0;
    end else begin
      clr_pulse <= (hold_cnt == HOLD_W'(HOLD_CYCLES - 2));
      if (hold_cnt != HOLD_W'(HOLD_CYCLES - 1)) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end
`else
  assign clr_pulse = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clr_pulse) begin
      state_nxt = ST_IDLE;
    end else if (press_pulse) begin
      unique case (state)
        ST_IDLE: state_nxt = ST_RUN;
        ST_RUN:  state_nxt = ST_STOP;
        ST_STOP: state_nxt = ST_RUN;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Encoding gives run and stop their own state bit, so both come straight off flops.
  assign bus.run         = state[0];
  assign bus.stop        = state[1];
  assign bus.press_pulse = press_pulse;
  assign bus.key_db      = key_db;
  assign bus.clr_pulse   = clr_pulse;

endmodule

// File: tb/tb_start_stop_ctrl.sv
// Scoreboard bench for start_stop_ctrl with short debounce/hold settings; HOLD_CLEAR_EN-aware.
module tb_start_stop_ctrl;

  localparam int unsigned DB   = 4;
  localparam int unsigned HOLD = 20;
  // key_n settled low after edge N -> press_pulse seen after edge N+LAT
  localparam int LAT = DB + 3;

  typedef struct {
    int   cyc;
    logic run;
    logic stop;
  } exp_t;

  logic clk    = 1'b0;
  logic clk_en = 1'b0;
  logic rst    = 1'b0;
  int   cyc    = 0;

  exp_t exp_q[$];
  int   clr_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   pend  = 1'b0;
  logic pend_run;
  logic pend_stop;

  start_stop_ctrl_if bus ();

  start_stop_ctrl #(
    .DEBOUNCE_CYCLES (DB),
    .CNT_W           (3),
    .HOLD_CYCLES     (HOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor: pops expectations whenever the DUT strobes, then checks the enables one cycle later.
  always @(negedge clk) begin
    exp_t e;
    int   c;
    if (pend) begin
      check("run_after_step", int'(bus.run), int'(pend_run));
      check("stop_after_step", int'(bus.stop), int'(pend_stop));
      pend = 1'b0;
    end
    if (bus.press_pulse === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_press_pulse", cyc, -1);
      end else begin
        e = exp_q.pop_front();
        check("press_pulse_cycle", cyc, e.cyc);
        pend      = 1'b1;
        pend_run  = e.run;
        pend_stop = e.stop;
      end
    end
    if (bus.clr_pulse === 1'b1) begin
      if (clr_q.size() == 0) begin
        check("unexpected_clr_pulse", cyc, -1);
      end else begin
        c = clr_q.pop_front();
        check("clr_pulse_cycle", cyc, c);
        pend      = 1'b1;
        pend_run  = 1'b0;
        pend_stop = 1'b0;
      end
    end
    if (bus.run === 1'b1 && bus.stop === 1'b1) check("run_stop_exclusive", 1, 0);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_press(input int at, input logic r, input logic s);
    exp_t e;
    e.cyc  = at;
    e.run  = r;
    e.stop = s;
    exp_q.push_back(e);
  endtask

  // Called #1 after a posedge; holds the key low for len cycles.
  task automatic press(input int len, input logic r, input logic s);
    bus.key_n = 1'b0;
    expect_press(cyc + LAT, r, s);
    tick(len);
    bus.key_n = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
  endtask

  initial begin
    int n;
    int r;
    bus.key_n = 1'b1;

    // 1: asynchronous reset with the clock stopped
    #12 rst = 1'b1;
    #1;
    check("rst_run", int'(bus.run), 0);
    check("rst_stop", int'(bus.stop), 0);
    check("rst_key_db", int'(bus.key_db), 0);
    check("rst_press_pulse", int'(bus.press_pulse), 0);
    check("rst_clr_pulse", int'(bus.clr_pulse), 0);
    clk_en = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(3);

    // 2: single long press from IDLE, no repeat while held
    press(30, 1'b1, 1'b0);
    tick(15);
    check("released_key_db", int'(bus.key_db), 0);

    // 3: three clean presses
    do_reset();
    press(10, 1'b1, 1'b0);
    tick(10);
    press(10, 1'b0, 1'b1);
    tick(10);
    press(10, 1'b1, 1'b0);
    tick(15);

    // 4: bouncing key, then steady low
    do_reset();
    bus.key_n = 1'b0; tick(2);
    bus.key_n = 1'b1; tick(1);
    bus.key_n = 1'b0; tick(3);
    bus.key_n = 1'b1; tick(1);
    check("bounce_key_db", int'(bus.key_db), 0);
    press(12, 1'b1, 1'b0);
    tick(15);

    // 5: reset while RUN with the key still held
    do_reset();
    n = cyc;
    bus.key_n = 1'b0;
    expect_press(n + LAT, 1'b1, 1'b0);
    tick(LAT + 2);
    check("pre_rst_run", int'(bus.run), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_run", int'(bus.run), 0);
    check("mid_rst_stop", int'(bus.stop), 0);
    check("mid_rst_key_db", int'(bus.key_db), 0);
    check("mid_rst_press_pulse", int'(bus.press_pulse), 0);
    tick(2);
    rst = 1'b0;
    r = cyc;
    expect_press(r + LAT, 1'b1, 1'b0);
    tick(DB + 2);
    check("post_rst_key_db", int'(bus.key_db), 1);
    tick(14);
    bus.key_n = 1'b1;
    tick(15);

    // 6: long press from STOPPED
    do_reset();
    press(10, 1'b1, 1'b0);
    tick(10);
    press(10, 1'b0, 1'b1);
    tick(10);
`ifdef HOLD_CLEAR_EN
    clr_q.push_back(cyc + int'(DB) + 1 + int'(HOLD));
    press(30, 1'b1, 1'b0);
    tick(15);
    check("hold_clear_run", int'(bus.run), 0);
    check("hold_clear_stop", int'(bus.stop), 0);
`else
    press(30, 1'b1, 1'b0);
    tick(15);
    check("long_press_run", int'(bus.run), 1);
    check("long_press_stop", int'(bus.stop), 0);
`endif

    tick(5);
    check("press_queue_left", exp_q.size(), 0);
    check("clr_queue_left", clr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
